// File: rtl/julia_pkg.sv
// Shared fixed-point definitions for the Julia/Mandelbrot pixel iteration datapath.
package julia_pkg;

    localparam int FX_WIDTH      = 20;
    localparam int FX_FRACTIONAL = 10;

    typedef logic signed [FX_WIDTH-1:0] fx_t;

    // Escape radius squared is 4.0; ESCAPE_UNITS is rescaled per instance FRACTIONAL.
    localparam int         ESCAPE_UNITS = 4;
    localparam int         ESCAPE_LIMIT = ESCAPE_UNITS << FX_FRACTIONAL;
    localparam logic [7:0] MAX_ITER     = 8'd255;

endpackage

// File: rtl/pixel_calculator_fx_mult.sv
// fx_mult: signed full-precision multiply, optional doubling, then arithmetic scaling shift.
module fx_mult #(
    parameter int WIDTH      = 20,
    parameter int FRACTIONAL = 10,
    parameter int DOUBLE     = 0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [2*WIDTH:0] p
);
    localparam int PW = 2 * WIDTH + 1;

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;

    // One guard bit above 2*WIDTH keeps (-min)*(-min) doubled from overflowing.
    assign full    = PW'(a) * PW'(b);
    assign shifted = (DOUBLE != 0) ? (full <<< 1) : full;
    assign p       = shifted >>> FRACTIONAL;

endmodule

// File: rtl/pixel_calculator.sv
// One z' = z^2 + c iteration step with escape freeze, latency 1 clock.
// Macro PIXEL_CALC_SATURATE_EN selects clamping instead of wrapping on overflow.
module pixel_calculator
    import julia_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int FRACTIONAL = 10,
    parameter int INTEGRAL   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] z_real_in,
    input  logic signed [WIDTH-1:0] z_imag_in,
    input  logic signed [WIDTH-1:0] c_real_in,
    input  logic signed [WIDTH-1:0] c_imag_in,
    input  logic        [7:0]       iteration_in,
    output logic signed [WIDTH-1:0] z_real_out,
    output logic signed [WIDTH-1:0] z_imag_out,
    output logic signed [WIDTH-1:0] size_squared_out,
    output logic        [7:0]       iteration_out
);
    localparam int PW = 2 * WIDTH + 1;
    localparam int EW = 2 * WIDTH + 3;

    localparam logic signed [EW-1:0] MAX_EXT = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_EXT = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] ESC_LIM = EW'(ESCAPE_UNITS) <<< FRACTIONAL;

    if (WIDTH != FRACTIONAL + INTEGRAL) begin : g_bad_format
        $error("pixel_calculator: WIDTH must equal FRACTIONAL + INTEGRAL");
    end

    function automatic logic signed [WIDTH-1:0] fit(input logic signed [EW-1:0] x);
`ifdef PIXEL_CALC_SATURATE_EN
        if (x > MAX_EXT) return MAX_EXT[WIDTH-1:0];
        if (x < MIN_EXT) return MIN_EXT[WIDTH-1:0];
        return x[WIDTH-1:0];
`else
        return x[WIDTH-1:0];
`endif
    endfunction

    logic signed [PW-1:0]    zr_sq_p0, zi_sq_p0, zrzi_dbl_p0;
    logic signed [PW-1:0]    nr_sq_p0, ni_sq_p0;
    logic signed [EW-1:0]    in_mag_p0, re_raw_p0, im_raw_p0, size_raw_p0;
    logic signed [WIDTH-1:0] re_fit_p0, im_fit_p0, size_fit_p0, in_mag_fit_p0;
    logic                    escaped_p0;
    logic        [7:0]       iter_next_p0;

    logic signed [WIDTH-1:0] z_real_p1, z_imag_p1, size_p1;
    logic        [7:0]       iter_p1;

    fx_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL), .DOUBLE(0)) u_zr_sq (
        .a(z_real_in), .b(z_real_in), .p(zr_sq_p0));
    fx_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL), .DOUBLE(0)) u_zi_sq (
        .a(z_imag_in), .b(z_imag_in), .p(zi_sq_p0));
    fx_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL), .DOUBLE(1)) u_zrzi (
        .a(z_real_in), .b(z_imag_in), .p(zrzi_dbl_p0));

    // Stage p0: new z from inputs, then |z'|^2 from the already-fitted z'.
    assign in_mag_p0  = EW'(zr_sq_p0) + EW'(zi_sq_p0);
    assign escaped_p0 = in_mag_p0 > ESC_LIM;
    assign re_raw_p0  = EW'(zr_sq_p0) - EW'(zi_sq_p0) + EW'(c_real_in);
    assign im_raw_p0  = EW'(zrzi_dbl_p0) + EW'(c_imag_in);
    assign re_fit_p0  = fit(re_raw_p0);
    assign im_fit_p0  = fit(im_raw_p0);

    fx_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL), .DOUBLE(0)) u_nr_sq (
        .a(re_fit_p0), .b(re_fit_p0), .p(nr_sq_p0));
    fx_mult #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL), .DOUBLE(0)) u_ni_sq (
        .a(im_fit_p0), .b(im_fit_p0), .p(ni_sq_p0));

    assign size_raw_p0   = EW'(nr_sq_p0) + EW'(ni_sq_p0);
    assign size_fit_p0   = fit(size_raw_p0);
    assign in_mag_fit_p0 = fit(in_mag_p0);
    assign iter_next_p0  = (iteration_in == MAX_ITER) ? MAX_ITER : iteration_in + 8'd1;

    // Stage p1: output registers; an escaped pixel passes through frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_real_p1 <= '0;
            z_imag_p1 <= '0;
            size_p1   <= '0;
            iter_p1   <= '0;
        end else if (escaped_p0) begin
            z_real_p1 <= z_real_in;
            z_imag_p1 <= z_imag_in;
            size_p1   <= in_mag_fit_p0;
            iter_p1   <= iteration_in;
        end else begin
            z_real_p1 <= re_fit_p0;
            z_imag_p1 <= im_fit_p0;
            size_p1   <= size_fit_p0;
            iter_p1   <= iter_next_p0;
        end
    end

    assign z_real_out       = z_real_p1;
    assign z_imag_out       = z_imag_p1;
    assign size_squared_out = size_p1;
    assign iteration_out    = iter_p1;

endmodule

// File: tb/tb_pixel_calculator.sv
// Directed bench for pixel_calculator: hand-computed Q10.10 vectors, escape, saturation/wrap, reset.
module tb_pixel_calculator;

    logic               tb_clk = 1'b0;
    logic               rst;
    logic signed [19:0] z_real_in, z_imag_in, c_real_in, c_imag_in;
    logic        [7:0]  iteration_in;
    logic signed [19:0] z_real_out, z_imag_out, size_squared_out;
    logic        [7:0]  iteration_out;

    int compared = 0;
    int mismatched = 0;

    pixel_calculator #(.WIDTH(20), .FRACTIONAL(10), .INTEGRAL(10)) dut (
        .clk             (tb_clk),
        .rst             (rst),
        .z_real_in       (z_real_in),
        .z_imag_in       (z_imag_in),
        .c_real_in       (c_real_in),
        .c_imag_in       (c_imag_in),
        .iteration_in    (iteration_in),
        .z_real_out      (z_real_out),
        .z_imag_out      (z_imag_out),
        .size_squared_out(size_squared_out),
        .iteration_out   (iteration_out)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int zr, input int zi, input int cr, input int ci, input int it);
        z_real_in    = 20'(zr);
        z_imag_in    = 20'(zi);
        c_real_in    = 20'(cr);
        c_imag_in    = 20'(ci);
        iteration_in = 8'(it);
        @(posedge tb_clk);
        #1;
    endtask

    task automatic expect4(input string tag, input int er, input int ei, input int es, input int eit);
        check({tag, ".re"},   z_real_out,       er);
        check({tag, ".im"},   z_imag_out,       ei);
        check({tag, ".size"}, size_squared_out, es);
        check({tag, ".iter"}, {24'd0, iteration_out}, eit);
    endtask

    initial begin
        rst = 1'b1;
        drive(1024, 512, -512, 512, 9);
        expect4("reset", 0, 0, 0, 0);
        rst = 1'b0;

        drive(1024, 512, -512, 512, 1);
        expect4("iter1", 256, 1536, 2368, 2);

        drive(256, 1536, -512, 512, 2);
        expect4("iter2", -2752, 1280, 8996, 3);

        drive(-2752, 1280, -512, 512, 3);
        expect4("escaped", -2752, 1280, 8996, 3);

        drive(0, 0, 0, 0, 255);
        expect4("iter_sat", 0, 0, 0, 255);

        // -2 >>> 10 floors to -1, not 0
        drive(-1, 1, 0, 0, 0);
        expect4("trunc_neg", 0, -1, 0, 1);

`ifdef PIXEL_CALC_SATURATE_EN
        drive(2048, 0, 511 * 1024, 0, 7);
        expect4("pos_over", 524287, 0, 524287, 8);
        drive(0, 2048, -524288, 0, 254);
        expect4("neg_over", -524288, 0, 524287, 255);
`else
        drive(2048, 0, 511 * 1024, 0, 7);
        expect4("pos_over", -521216, 0, 9216, 8);
        drive(0, 2048, -524288, 0, 254);
        expect4("neg_over", 520192, 0, 16384, 255);
`endif

        drive(1024, 512, -512, 512, 1);
        expect4("pre_rst", 256, 1536, 2368, 2);
        rst = 1'b1;
        drive(256, 1536, -512, 512, 2);
        expect4("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        drive(256, 1536, -512, 512, 2);
        expect4("post_rst", -2752, 1280, 8996, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
